// File: rtl/tx_arb_pkg.sv
// Shared definitions for the transmit frame arbiter: FSM encoding, grant index
// width and the drain counter limit.
package tx_arb_pkg;

    localparam int GRANT_IDX_W      = 3;
    localparam int DRAIN_CYCLES_MAX = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Round-robin pointer successor, wrapping after the last source.
    function automatic logic [GRANT_IDX_W-1:0] next_ptr(
        input logic [GRANT_IDX_W-1:0] idx,
        input int                     num
    );
        return (int'(idx) >= num - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after the
// pointer, wrapping modulo NUM_SOURCES.
module tx_arb_rr_pick
    import tx_arb_pkg::*;
#(
    parameter int NUM_SOURCES = 2
) (
    input  logic [NUM_SOURCES-1:0] request,
    input  logic [GRANT_IDX_W-1:0] pointer,
    output logic [GRANT_IDX_W-1:0] winner,
    output logic                   found
);

    int idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < NUM_SOURCES; off++) begin
            idx = (int'(pointer) + off) % NUM_SOURCES;
            if (!found && request[idx]) begin
                winner = GRANT_IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Per-frame arbiter sharing the MAC transmit FIFO interface between several
// frame queues. Define TX_ARB_STRICT_PRIO_EN to give source 0 strict priority.
module tx_frame_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_SOURCES  = 2,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [8*NUM_SOURCES-1:0] src_data,
    input  logic [NUM_SOURCES-1:0]   src_start,
    input  logic [NUM_SOURCES-1:0]   src_end,
    input  logic [NUM_SOURCES-1:0]   src_available,
    output logic [NUM_SOURCES-1:0]   src_read,
    output logic [NUM_SOURCES-1:0]   src_retry,
    output logic [7:0]               fifo_data,
    output logic                     fifo_data_start,
    output logic                     fifo_data_end,
    output logic                     fifo_data_available,
    input  logic                     fifo_data_read,
    input  logic                     fifo_retry,
    output logic                     grant_valid,
    output logic [GRANT_IDX_W-1:0]   grant_index
);

    localparam logic [3:0] DRAIN_LOAD =
        4'((DRAIN_CYCLES > DRAIN_CYCLES_MAX) ? DRAIN_CYCLES_MAX : DRAIN_CYCLES);

    arb_state_t             state;
    logic [GRANT_IDX_W-1:0] rr_ptr;
    logic [3:0]             drain_cnt;
    logic                   retry_q;

    logic [NUM_SOURCES-1:0] pick_req;
    logic [GRANT_IDX_W-1:0] pick_winner;
    logic                   pick_found;
    logic [GRANT_IDX_W-1:0] winner;
    logic                   winner_valid;
    logic                   advance_ptr;
    logic                   sel_end;

    tx_arb_rr_pick #(
        .NUM_SOURCES(NUM_SOURCES)
    ) u_pick (
        .request(pick_req),
        .pointer(rr_ptr),
        .winner (pick_winner),
        .found  (pick_found)
    );

`ifdef TX_ARB_STRICT_PRIO_EN
    // Source 0 bypasses the rotation; the others share the pointer among themselves.
    always_comb begin
        pick_req     = src_available;
        pick_req[0]  = 1'b0;
        winner       = src_available[0] ? '0 : pick_winner;
        winner_valid = src_available[0] | pick_found;
        advance_ptr  = !src_available[0];
    end
`else
    always_comb begin
        pick_req     = src_available;
        winner       = pick_winner;
        winner_valid = pick_found;
        advance_ptr  = 1'b1;
    end
`endif

    always_comb begin
        src_read            = '0;
        src_retry           = '0;
        fifo_data           = '0;
        fifo_data_start     = 1'b0;
        fifo_data_end       = 1'b0;
        fifo_data_available = 1'b0;
        sel_end             = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (grant_valid && grant_index == GRANT_IDX_W'(i)) begin
                src_retry[i] = fifo_retry;
                sel_end      = src_end[i];
                if (state == GRANT) begin
                    src_read[i]         = fifo_data_read;
                    fifo_data           = src_data[8*i +: 8];
                    fifo_data_start     = src_start[i];
                    fifo_data_end       = src_end[i];
                    fifo_data_available = src_available[i];
                end
            end
        end
    end

    // Retry beats end-of-frame in GRANT; a fresh retry edge in DRAIN reopens the frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_index <= '0;
            rr_ptr      <= '0;
            drain_cnt   <= '0;
            retry_q     <= 1'b0;
        end else begin
            retry_q <= fifo_retry;
            case (state)
                IDLE: begin
                    if (winner_valid) begin
                        grant_index <= winner;
                        grant_valid <= 1'b1;
                        if (advance_ptr) begin
                            rr_ptr <= next_ptr(winner, NUM_SOURCES);
                        end
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!fifo_retry && fifo_data_read && sel_end) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_retry && !retry_q) begin
                        drain_cnt <= '0;
                        state     <= GRANT;
                    end else if (drain_cnt <= 4'd1) begin
                        drain_cnt   <= '0;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
